// File: rtl/flpt_band_add_sched.sv
// Round-robin scheduler feeding NREQ band operand pairs into a shared 2-stage float add (align, add/normalize).
// Optional FLPT_SAT_EN: saturate mantissa/exponent on exponent overflow instead of wrapping.
module flpt_band_add_sched #(
  parameter int NREQ = 4,
  parameter int MW   = 5,
  parameter int EW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*MW-1:0] op_m1,
  input  logic [NREQ*EW-1:0] op_e1,
  input  logic [NREQ*MW-1:0] op_m2,
  input  logic [NREQ*EW-1:0] op_e2,
  output logic [NREQ-1:0]    ack,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MW-1:0]      res_m,
  output logic [EW-1:0]      res_e,
  output logic [2:0]         res_band
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0][MW-1:0] m1_a, m2_a;
  logic [NREQ-1:0][EW-1:0] e1_a, e2_a;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign m1_a[g] = op_m1[g*MW +: MW];
    assign m2_a[g] = op_m2[g*MW +: MW];
    assign e1_a[g] = op_e1[g*EW +: EW];
    assign e2_a[g] = op_e2[g*EW +: EW];
  end

  logic [PW-1:0] rr_q, rr_d;
  logic          s1_vld_q, s1_vld_d;
  logic [MW-1:0] s1_m1_q, s1_m1_d, s1_m2_q, s1_m2_d;
  logic [EW-1:0] s1_e_q, s1_e_d;
  logic [PW-1:0] s1_band_q, s1_band_d;
  logic          res_valid_q, res_valid_d;
  logic [MW-1:0] res_m_q, res_m_d;
  logic [EW-1:0] res_e_q, res_e_d;
  logic [2:0]    res_band_q, res_band_d;

  logic          stall, s1_open, gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   scan;

  assign stall   = res_valid_q && !res_ready;
  // S1 accepts a new grant if it is empty or drains into S2 this cycle
  assign s1_open = !s1_vld_q || !stall;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!gnt_vld && req[scan[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[PW-1:0];
      end
    end
    if (!rst_n || !s1_open) gnt_vld = 1'b0;
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_ack
    assign ack[g] = gnt_vld && (gnt_idx == PW'(g));
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
  end

  logic [MW-1:0] g_m1, g_m2, al_m1, al_m2;
  logic [EW-1:0] g_e1, g_e2, al_e, diff;

  always_comb begin
    g_m1  = m1_a[gnt_idx];
    g_m2  = m2_a[gnt_idx];
    g_e1  = e1_a[gnt_idx];
    g_e2  = e2_a[gnt_idx];
    al_m1 = g_m1;
    al_m2 = g_m2;
    if (g_e1 >= g_e2) begin
      diff  = g_e1 - g_e2;
      al_e  = g_e1;
      al_m2 = (32'(diff) >= MW) ? '0 : g_m2 >> diff;
    end else begin
      diff  = g_e2 - g_e1;
      al_e  = g_e2;
      al_m1 = (32'(diff) >= MW) ? '0 : g_m1 >> diff;
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_m1_d   = s1_m1_q;
    s1_m2_d   = s1_m2_q;
    s1_e_d    = s1_e_q;
    s1_band_d = s1_band_q;
    if (s1_open) begin
      s1_vld_d = gnt_vld;
      if (gnt_vld) begin
        s1_m1_d   = al_m1;
        s1_m2_d   = al_m2;
        s1_e_d    = al_e;
        s1_band_d = gnt_idx;
      end
    end
  end

  logic [MW:0] sum;
  logic [EW:0] e_inc;

  always_comb begin
    sum         = {1'b0, s1_m1_q} + {1'b0, s1_m2_q};
    e_inc       = {1'b0, s1_e_q} + (EW+1)'(1);
    res_valid_d = res_valid_q;
    res_m_d     = res_m_q;
    res_e_d     = res_e_q;
    res_band_d  = res_band_q;
    if (!stall) begin
      res_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        res_band_d = 3'(s1_band_q);
        if (sum[MW]) begin
          res_m_d = sum[MW:1];
          res_e_d = e_inc[EW-1:0];
`ifdef FLPT_SAT_EN
          if (e_inc[EW]) begin
            res_m_d = '1;
            res_e_d = '1;
          end
`endif
        end else begin
          res_m_d = sum[MW-1:0];
          res_e_d = s1_e_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      s1_vld_q    <= 1'b0;
      s1_m1_q     <= '0;
      s1_m2_q     <= '0;
      s1_e_q      <= '0;
      s1_band_q   <= '0;
      res_valid_q <= 1'b0;
      res_m_q     <= '0;
      res_e_q     <= '0;
      res_band_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      s1_vld_q    <= s1_vld_d;
      s1_m1_q     <= s1_m1_d;
      s1_m2_q     <= s1_m2_d;
      s1_e_q      <= s1_e_d;
      s1_band_q   <= s1_band_d;
      res_valid_q <= res_valid_d;
      res_m_q     <= res_m_d;
      res_e_q     <= res_e_d;
      res_band_q  <= res_band_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_m     = res_m_q;
  assign res_e     = res_e_q;
  assign res_band  = res_band_q;
endmodule
